// File: rtl/uart_core_cfg_if.sv
// ---------------------------------------------------------------------------
// uart_core_cfg_if
//   System-side byte interface of the configurable UART core.
//
//   Handshake: the system offers a byte by holding newdata=1 with dintx
//   stable. The core takes it in any cycle where newdata=1 and txbusy=0.
//   txbusy rises the cycle after that and falls in the same cycle as the
//   one-cycle donetx pulse. newdata while txbusy=1 is ignored and is not
//   queued. donerx is a one-cycle pulse. doutrx, parity_err and frame_err
//   are valid in the donerx cycle and hold until the next donerx.
//
//   Signals:
//     dintx[7:0]   TX byte, LSB first; bits above DATA_BITS-1 are ignored
//     newdata      TX request
//     txbusy       transmitter owns a byte
//     donetx       end of the last stop bit
//     doutrx[7:0]  received byte, zero-extended
//     donerx       frame received
//     parity_err   parity mismatch on the last frame
//     frame_err    first stop bit sampled low on the last frame
//
//   Modports: master = system side, slave = UART core.
// ---------------------------------------------------------------------------
interface uart_core_cfg_if;
  logic [7:0] dintx;
  logic       newdata;
  logic       txbusy;
  logic       donetx;
  logic [7:0] doutrx;
  logic       donerx;
  logic       parity_err;
  logic       frame_err;

  modport master (
    output dintx, newdata,
    input  txbusy, donetx, doutrx, donerx, parity_err, frame_err
  );

  modport slave (
    input  dintx, newdata,
    output txbusy, donetx, doutrx, donerx, parity_err, frame_err
  );
endinterface

// File: rtl/uart_core_cfg.sv
// ---------------------------------------------------------------------------
// uart_core_cfg
//   Full-duplex UART with a compile-time frame format (5..8 data bits,
//   none/odd/even parity, 1 or 2 stop bits). TX and RX share one free-running
//   16x baud tick generator. RX synchronises the line with two flops, samples
//   mid-bit, rejects short start glitches and reports parity/framing errors.
//
//   Parameters:
//     CLK_FREQ   system clock in Hz
//     BAUD_RATE  serial bit rate in bit/s
//     DATA_BITS  5..8
//     PARITY     0 none, 1 odd, 2 even
//     STOP_BITS  1 or 2 (TX sends all, RX checks the first)
//
//   Ports:
//     clk     system clock, rising edge
//     rst     synchronous active-low reset
//     rx      serial input, asynchronous, idle high
//     tx      serial output, idle high (registered)
//     sys     byte interface (uart_core_cfg_if.slave)
//     tx_fsm  current TX FSM state encoding
//     rx_fsm  current RX FSM state encoding
// ---------------------------------------------------------------------------
module uart_core_cfg #(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  output logic            tx,
  uart_core_cfg_if.slave  sys,
  output logic [2:0]      tx_fsm,
  output logic [2:0]      rx_fsm
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * 16);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [7:0]    DATA_MASK = 8'((16'd1 << DATA_BITS) - 16'd1);
  localparam logic [2:0]    LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [4:0]    STOP_LAST = 5'(16 * STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);

  // -------------------------------------------------------------------------
  // Baud tick: one-cycle pulse every DIV clocks, never stopped or re-phased
  // except by reset.
  // -------------------------------------------------------------------------
  logic [CW-1:0] div_cnt;
  logic          tick;

  always_ff @(posedge clk) begin
    if (!rst)                   div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end

  assign tick = (div_cnt == DIV_LAST);

  // -------------------------------------------------------------------------
  // TX FSM. TX_ARM holds the accepted byte until the next tick so that the
  // start bit is exactly 16 full ticks long.
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_ARM    = 3'd1,
    TX_START  = 3'd2,
    TX_DATA   = 3'd3,
    TX_PARITY = 3'd4,
    TX_STOP   = 3'd5
  } tx_state_t;

  tx_state_t  tx_state, tx_state_d;
  logic [7:0] tx_shreg, tx_shreg_d;
  logic [4:0] tx_tcnt, tx_tcnt_d;
  logic [2:0] tx_bit, tx_bit_d;
  logic       tx_par, tx_par_d;
  logic       tx_q, tx_d;
  logic       donetx_q, donetx_d;

  always_comb begin
    tx_state_d = tx_state;
    tx_shreg_d = tx_shreg;
    tx_tcnt_d  = tx_tcnt;
    tx_bit_d   = tx_bit;
    tx_par_d   = tx_par;
    donetx_d   = 1'b0;

    case (tx_state)
      TX_IDLE: begin
        // IDLE implies txbusy=0, so newdata alone is an acceptance.
        if (sys.newdata) begin
          tx_shreg_d = sys.dintx & DATA_MASK;
          tx_par_d   = (^(sys.dintx & DATA_MASK)) ^ PAR_ODD;
          tx_state_d = TX_ARM;
        end
      end
      TX_ARM: begin
        if (tick) begin
          tx_tcnt_d  = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt_d  = '0;
            tx_bit_d   = '0;
            tx_state_d = TX_DATA;
          end else begin
            tx_tcnt_d = tx_tcnt + 5'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt_d  = '0;
            tx_shreg_d = tx_shreg >> 1;
            if (tx_bit == LAST_BIT) begin
              tx_state_d = (PARITY != 0) ? TX_PARITY : TX_STOP;
            end else begin
              tx_bit_d = tx_bit + 3'd1;
            end
          end else begin
            tx_tcnt_d = tx_tcnt + 5'd1;
          end
        end
      end
      TX_PARITY: begin
        if (tick) begin
          if (tx_tcnt == 5'd15) begin
            tx_tcnt_d  = '0;
            tx_state_d = TX_STOP;
          end else begin
            tx_tcnt_d = tx_tcnt + 5'd1;
          end
        end
      end
      TX_STOP: begin
        if (tick) begin
          if (tx_tcnt == STOP_LAST) begin
            tx_tcnt_d  = '0;
            donetx_d   = 1'b1;
            tx_state_d = TX_IDLE;
          end else begin
            tx_tcnt_d = tx_tcnt + 5'd1;
          end
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase

    // Line level is derived from the next state so the registered tx
    // changes in the same cycle as the state register.
    case (tx_state_d)
      TX_START:  tx_d = 1'b0;
      TX_DATA:   tx_d = tx_shreg_d[0];
      TX_PARITY: tx_d = tx_par_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_shreg <= '0;
      tx_tcnt  <= '0;
      tx_bit   <= '0;
      tx_par   <= 1'b0;
      tx_q     <= 1'b1;
      donetx_q <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_shreg <= tx_shreg_d;
      tx_tcnt  <= tx_tcnt_d;
      tx_bit   <= tx_bit_d;
      tx_par   <= tx_par_d;
      tx_q     <= tx_d;
      donetx_q <= donetx_d;
    end
  end

  assign tx         = tx_q;
  assign sys.txbusy = (tx_state != TX_IDLE);
  assign sys.donetx = donetx_q;
  assign tx_fsm     = tx_state;

  // -------------------------------------------------------------------------
  // RX line synchroniser and edge history. All reset high (idle line) so a
  // reset never fakes a falling edge.
  // -------------------------------------------------------------------------
  logic rx_m, rx_s, rx_prev;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      rx_prev <= rx_s;
    end
  end

  // -------------------------------------------------------------------------
  // RX FSM. A frame only starts on a 1->0 edge of the synchronised line, so
  // after a break (line held low) nothing restarts until the line has been
  // high again.
  // -------------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_t;

  rx_state_t  rx_state, rx_state_d;
  logic [3:0] rx_tcnt, rx_tcnt_d;
  logic [2:0] rx_bit, rx_bit_d;
  logic [7:0] rx_data, rx_data_d;
  logic       rx_par, rx_par_d;
  logic [7:0] doutrx_q, doutrx_d;
  logic       donerx_q, donerx_d;
  logic       perr_q, perr_d;
  logic       ferr_q, ferr_d;

  always_comb begin
    rx_state_d = rx_state;
    rx_tcnt_d  = rx_tcnt;
    rx_bit_d   = rx_bit;
    rx_data_d  = rx_data;
    rx_par_d   = rx_par;
    doutrx_d   = doutrx_q;
    donerx_d   = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    case (rx_state)
      RX_IDLE: begin
        if (rx_prev && !rx_s) begin
          rx_tcnt_d  = '0;
          rx_data_d  = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tcnt == 4'd7) begin
            // Mid start bit: a high line here means the edge was a glitch.
            rx_tcnt_d = '0;
            rx_bit_d  = '0;
            rx_state_d = rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_d = rx_tcnt + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_d          = '0;
            rx_data_d[rx_bit]  = rx_s;
            if (rx_bit == LAST_BIT) begin
              rx_state_d = (PARITY != 0) ? RX_PARITY : RX_STOP;
            end else begin
              rx_bit_d = rx_bit + 3'd1;
            end
          end else begin
            rx_tcnt_d = rx_tcnt + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (tick) begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_d  = '0;
            rx_par_d   = rx_s;
            rx_state_d = RX_STOP;
          end else begin
            rx_tcnt_d = rx_tcnt + 4'd1;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          if (rx_tcnt == 4'd15) begin
            rx_tcnt_d  = '0;
            doutrx_d   = rx_data;
            perr_d     = (PARITY != 0) && (rx_par != ((^rx_data) ^ PAR_ODD));
            ferr_d     = !rx_s;
            donerx_d   = 1'b1;
            rx_state_d = RX_IDLE;
          end else begin
            rx_tcnt_d = rx_tcnt + 4'd1;
          end
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_state <= RX_IDLE;
      rx_tcnt  <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_par   <= 1'b0;
      doutrx_q <= '0;
      donerx_q <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      rx_state <= rx_state_d;
      rx_tcnt  <= rx_tcnt_d;
      rx_bit   <= rx_bit_d;
      rx_data  <= rx_data_d;
      rx_par   <= rx_par_d;
      doutrx_q <= doutrx_d;
      donerx_q <= donerx_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
    end
  end

  assign sys.doutrx     = doutrx_q;
  assign sys.donerx     = donerx_q;
  assign sys.parity_err = perr_q;
  assign sys.frame_err  = ferr_q;
  assign rx_fsm         = rx_state;

endmodule

// File: tb/tb_uart_core_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_core_cfg
//   Directed bench for uart_core_cfg at 1.536 MHz / 9600 baud (DIV=10,
//   160 clocks per bit). Three instances share clock and reset:
//     u0  8N1, rx looped from tx or driven by the bench (loop0)
//     u1  8E1, rx looped from tx or driven by the bench (loop1)
//     u2  5O2, rx looped from tx
//   A single monitor process records donerx pulses and the captured data.
// ---------------------------------------------------------------------------
module tb_uart_core_cfg;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  uart_core_cfg_if if0 ();
  uart_core_cfg_if if1 ();
  uart_core_cfg_if if2 ();

  logic tx0, tx1, tx2, rx0, rx1, rx2;
  logic rx0_drv = 1'b1;
  logic rx1_drv = 1'b1;
  logic loop0 = 1'b1;
  logic loop1 = 1'b1;
  logic [2:0] txf0, rxf0, txf1, rxf1, txf2, rxf2;

  assign rx0 = loop0 ? tx0 : rx0_drv;
  assign rx1 = loop1 ? tx1 : rx1_drv;
  assign rx2 = tx2;

  uart_core_cfg #(.CLK_FREQ(1536000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .tx(tx0), .sys(if0), .tx_fsm(txf0), .rx_fsm(rxf0));
  uart_core_cfg #(.CLK_FREQ(1536000), .BAUD_RATE(9600), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .tx(tx1), .sys(if1), .tx_fsm(txf1), .rx_fsm(rxf1));
  uart_core_cfg #(.CLK_FREQ(1536000), .BAUD_RATE(9600), .DATA_BITS(5), .PARITY(1), .STOP_BITS(2)) u2 (
    .clk(clk), .rst(rst), .rx(rx2), .tx(tx2), .sys(if2), .tx_fsm(txf2), .rx_fsm(rxf2));

  // ---------------- donerx monitor ----------------
  int rxc0 = 0, rxc1 = 0, rxc2 = 0;
  logic [7:0] rxd0 = '0, rxd1 = '0, rxd2 = '0;
  logic pe0 = 1'b0, pe1 = 1'b0, pe2 = 1'b0;
  logic fe0 = 1'b0, fe1 = 1'b0, fe2 = 1'b0;

  always @(negedge clk) begin
    if (if0.donerx === 1'b1) begin
      rxc0 <= rxc0 + 1; rxd0 <= if0.doutrx; pe0 <= if0.parity_err; fe0 <= if0.frame_err;
    end
    if (if1.donerx === 1'b1) begin
      rxc1 <= rxc1 + 1; rxd1 <= if1.doutrx; pe1 <= if1.parity_err; fe1 <= if1.frame_err;
    end
    if (if2.donerx === 1'b1) begin
      rxc2 <= rxc2 + 1; rxd2 <= if2.doutrx; pe2 <= if2.parity_err; fe2 <= if2.frame_err;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic sel_tx(input int sel);
    return (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
  endfunction

  function automatic logic sel_donetx(input int sel);
    return (sel == 0) ? if0.donetx : (sel == 1) ? if1.donetx : if2.donetx;
  endfunction

  // Waits for the start bit, then samples nbits at bit centres. bits[0]=start.
  task automatic capture_tx(input int sel, input int nbits, output logic [15:0] bits);
    int w;
    bits = '0;
    w = 0;
    while (sel_tx(sel) !== 1'b0 && w < 1000) begin
      @(negedge clk);
      w++;
    end
    repeat (80) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) repeat (160) @(negedge clk);
      bits[i] = sel_tx(sel);
    end
  endtask

  // Counts negedges until donetx is seen (bounded).
  task automatic wait_donetx(input int sel, input int limit, output int k);
    k = 0;
    while (sel_donetx(sel) !== 1'b1 && k < limit) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic drive_rx(input int sel, input logic [15:0] bits, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (sel == 0) rx0_drv = bits[i]; else rx1_drv = bits[i];
      repeat (160) @(negedge clk);
    end
    if (sel == 0) rx0_drv = 1'b1; else rx1_drv = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b0;
    if0.newdata = 1'b0; if0.dintx = '0;
    if1.newdata = 1'b0; if1.dintx = '0;
    if2.newdata = 1'b0; if2.dintx = '0;
    repeat (5) @(negedge clk);
    n_cmp++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx0); end
    n_cmp++; if (if0.txbusy !== 1'b0) begin n_fail++; $display("FAIL reset_txbusy: got %b want 0", if0.txbusy); end
    n_cmp++; if (if0.donetx !== 1'b0) begin n_fail++; $display("FAIL reset_donetx: got %b want 0", if0.donetx); end
    n_cmp++; if (if0.donerx !== 1'b0) begin n_fail++; $display("FAIL reset_donerx: got %b want 0", if0.donerx); end
    n_cmp++; if (if0.doutrx !== 8'h00) begin n_fail++; $display("FAIL reset_doutrx: got %h want 00", if0.doutrx); end
    n_cmp++; if (if0.parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr: got %b want 0", if0.parity_err); end
    n_cmp++; if (if0.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b want 0", if0.frame_err); end
    n_cmp++; if (tx2 !== 1'b1) begin n_fail++; $display("FAIL reset_tx2: got %b want 1", tx2); end
    rst = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_8n1_loop;
    logic [15:0] bits;
    int k, c;
    c = rxc0;
    loop0 = 1'b1;
    if0.dintx = 8'hA5; if0.newdata = 1'b1;
    @(negedge clk);
    if0.newdata = 1'b0;
    n_cmp++; if (if0.txbusy !== 1'b1) begin n_fail++; $display("FAIL a5_txbusy_after_accept: got %b want 1", if0.txbusy); end
    capture_tx(0, 10, bits);
    n_cmp++; if (bits[9:0] !== 10'b1101001010) begin n_fail++; $display("FAIL a5_tx_bits: got %b want 1101001010", bits[9:0]); end
    wait_donetx(0, 400, k);
    n_cmp++; if (k !== 80) begin n_fail++; $display("FAIL a5_donetx_time: got %0d want 80", k); end
    n_cmp++; if (if0.txbusy !== 1'b0) begin n_fail++; $display("FAIL a5_txbusy_at_done: got %b want 0", if0.txbusy); end
    @(negedge clk);
    n_cmp++; if (if0.donetx !== 1'b0) begin n_fail++; $display("FAIL a5_donetx_width: got %b want 0", if0.donetx); end
    repeat (5) @(negedge clk);
    n_cmp++; if (rxc0 - c !== 1) begin n_fail++; $display("FAIL a5_donerx_count: got %0d want 1", rxc0 - c); end
    n_cmp++; if (rxd0 !== 8'hA5) begin n_fail++; $display("FAIL a5_doutrx: got %h want a5", rxd0); end
    n_cmp++; if ({pe0, fe0} !== 2'b00) begin n_fail++; $display("FAIL a5_errors: got %b want 00", {pe0, fe0}); end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    int k, c, lows;
    c = rxc0;
    if0.dintx = 8'h5A; if0.newdata = 1'b1;
    @(negedge clk);
    if0.newdata = 1'b0;
    repeat (300) @(negedge clk);
    if0.dintx = 8'hFF; if0.newdata = 1'b1;
    @(negedge clk);
    if0.newdata = 1'b0;
    wait_donetx(0, 3000, k);
    n_cmp++; if (k >= 3000) begin n_fail++; $display("FAIL busy_donetx_timeout: got %0d want <3000", k); end
    repeat (5) @(negedge clk);
    n_cmp++; if (rxd0 !== 8'h5A) begin n_fail++; $display("FAIL busy_doutrx: got %h want 5a", rxd0); end
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx0 === 1'b0) lows++;
    end
    n_cmp++; if (lows !== 0) begin n_fail++; $display("FAIL busy_no_second_frame: got %0d low cycles want 0", lows); end
    n_cmp++; if (rxc0 - c !== 1) begin n_fail++; $display("FAIL busy_donerx_count: got %0d want 1", rxc0 - c); end
  endtask

  task automatic test_back_to_back;
    int k, c;
    c = rxc0;
    if0.dintx = 8'h81; if0.newdata = 1'b1;
    wait_donetx(0, 3000, k);
    // The edge that ends this cycle re-accepts with the new byte.
    if0.dintx = 8'h7E;
    n_cmp++; if (rxd0 !== 8'h81) begin n_fail++; $display("FAIL b2b_first_doutrx: got %h want 81", rxd0); end
    @(negedge clk);
    if0.newdata = 1'b0;
    n_cmp++; if (if0.txbusy !== 1'b1) begin n_fail++; $display("FAIL b2b_reaccept: got %b want 1", if0.txbusy); end
    wait_donetx(0, 3000, k);
    n_cmp++; if (k >= 3000) begin n_fail++; $display("FAIL b2b_donetx_timeout: got %0d want <3000", k); end
    repeat (5) @(negedge clk);
    n_cmp++; if (rxd0 !== 8'h7E) begin n_fail++; $display("FAIL b2b_second_doutrx: got %h want 7e", rxd0); end
    n_cmp++; if (rxc0 - c !== 2) begin n_fail++; $display("FAIL b2b_donerx_count: got %0d want 2", rxc0 - c); end
    repeat (50) @(negedge clk);
  endtask

  task automatic test_parity_even;
    logic [15:0] bits;
    int k, c;
    c = rxc1;
    loop1 = 1'b1;
    if1.dintx = 8'h07; if1.newdata = 1'b1;
    @(negedge clk);
    if1.newdata = 1'b0;
    capture_tx(1, 11, bits);
    n_cmp++; if (bits[9] !== 1'b1) begin n_fail++; $display("FAIL even_parity_bit: got %b want 1", bits[9]); end
    n_cmp++; if (bits[10:0] !== 11'b11000001110) begin n_fail++; $display("FAIL even_tx_bits: got %b want 11000001110", bits[10:0]); end
    wait_donetx(1, 400, k);
    n_cmp++; if (k !== 80) begin n_fail++; $display("FAIL even_donetx_time: got %0d want 80", k); end
    repeat (5) @(negedge clk);
    n_cmp++; if ({rxd1, pe1, fe1} !== {8'h07, 2'b00}) begin n_fail++; $display("FAIL even_loop_rx: got %h/%b%b want 07/00", rxd1, pe1, fe1); end
    loop1 = 1'b0; rx1_drv = 1'b1;
    repeat (50) @(negedge clk);
    drive_rx(1, 16'b00000_10000001110, 11);
    repeat (20) @(negedge clk);
    n_cmp++; if (rxc1 - c !== 2) begin n_fail++; $display("FAIL even_donerx_count: got %0d want 2", rxc1 - c); end
    n_cmp++; if (rxd1 !== 8'h07) begin n_fail++; $display("FAIL even_bad_doutrx: got %h want 07", rxd1); end
    n_cmp++; if (pe1 !== 1'b1) begin n_fail++; $display("FAIL even_parity_err: got %b want 1", pe1); end
    n_cmp++; if (fe1 !== 1'b0) begin n_fail++; $display("FAIL even_frame_err: got %b want 0", fe1); end
  endtask

  task automatic test_frame_err;
    int c;
    loop0 = 1'b0; rx0_drv = 1'b1;
    repeat (50) @(negedge clk);
    c = rxc0;
    drive_rx(0, 16'b000000_0001111000, 10);
    repeat (20) @(negedge clk);
    n_cmp++; if (rxc0 - c !== 1) begin n_fail++; $display("FAIL ferr_donerx_count: got %0d want 1", rxc0 - c); end
    n_cmp++; if (rxd0 !== 8'h3C) begin n_fail++; $display("FAIL ferr_doutrx: got %h want 3c", rxd0); end
    n_cmp++; if (fe0 !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %b want 1", fe0); end
    n_cmp++; if (pe0 !== 1'b0) begin n_fail++; $display("FAIL ferr_perr: got %b want 0", pe0); end
  endtask

  task automatic test_break;
    int c;
    loop0 = 1'b0; rx0_drv = 1'b1;
    repeat (200) @(negedge clk);
    c = rxc0;
    rx0_drv = 1'b0;
    repeat (4800) @(negedge clk);
    rx0_drv = 1'b1;
    repeat (400) @(negedge clk);
    n_cmp++; if (rxc0 - c !== 1) begin n_fail++; $display("FAIL break_donerx_count: got %0d want 1", rxc0 - c); end
    n_cmp++; if ({rxd0, fe0} !== {8'h00, 1'b1}) begin n_fail++; $display("FAIL break_data_ferr: got %h/%b want 00/1", rxd0, fe0); end
  endtask

  task automatic test_glitch;
    int c;
    loop0 = 1'b0; rx0_drv = 1'b1;
    repeat (50) @(negedge clk);
    c = rxc0;
    rx0_drv = 1'b0;
    repeat (40) @(negedge clk);
    rx0_drv = 1'b1;
    repeat (400) @(negedge clk);
    n_cmp++; if (rxc0 - c !== 0) begin n_fail++; $display("FAIL glitch_no_donerx: got %0d want 0", rxc0 - c); end
    n_cmp++; if (rxf0 !== 3'd0) begin n_fail++; $display("FAIL glitch_rx_idle: got %0d want 0", rxf0); end
    drive_rx(0, 16'b000000_1010101010, 10);
    repeat (20) @(negedge clk);
    n_cmp++; if (rxc0 - c !== 1) begin n_fail++; $display("FAIL glitch_next_count: got %0d want 1", rxc0 - c); end
    n_cmp++; if ({rxd0, pe0, fe0} !== {8'h55, 2'b00}) begin n_fail++; $display("FAIL glitch_next_frame: got %h/%b%b want 55/00", rxd0, pe0, fe0); end
  endtask

  task automatic test_5o2;
    logic [15:0] bits;
    int k, c;
    c = rxc2;
    if2.dintx = 8'hF3; if2.newdata = 1'b1;
    @(negedge clk);
    if2.newdata = 1'b0;
    capture_tx(2, 9, bits);
    n_cmp++; if (bits[8:0] !== 9'b110100110) begin n_fail++; $display("FAIL 5o2_tx_bits: got %b want 110100110", bits[8:0]); end
    wait_donetx(2, 400, k);
    n_cmp++; if (k !== 80) begin n_fail++; $display("FAIL 5o2_donetx_time: got %0d want 80", k); end
    repeat (5) @(negedge clk);
    n_cmp++; if (rxc2 - c !== 1) begin n_fail++; $display("FAIL 5o2_donerx_count: got %0d want 1", rxc2 - c); end
    n_cmp++; if ({rxd2, pe2, fe2} !== {8'h13, 2'b00}) begin n_fail++; $display("FAIL 5o2_rx: got %h/%b%b want 13/00", rxd2, pe2, fe2); end
  endtask

  task automatic test_reset_mid;
    int c;
    loop0 = 1'b1; rx0_drv = 1'b1;
    repeat (50) @(negedge clk);
    c = rxc0;
    if0.dintx = 8'h96; if0.newdata = 1'b1;
    @(negedge clk);
    if0.newdata = 1'b0;
    repeat (250) @(negedge clk);
    n_cmp++; if ({txf0, tx0} !== {3'd3, 1'b0}) begin n_fail++; $display("FAIL midrst_pre: got state %0d tx %b want 3/0", txf0, tx0); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b want 1", tx0); end
    n_cmp++; if (if0.txbusy !== 1'b0) begin n_fail++; $display("FAIL midrst_txbusy: got %b want 0", if0.txbusy); end
    rst = 1'b1;
    repeat (2000) @(negedge clk);
    n_cmp++; if (rxc0 - c !== 0) begin n_fail++; $display("FAIL midrst_no_donerx: got %0d want 0", rxc0 - c); end
    n_cmp++; if (tx0 !== 1'b1) begin n_fail++; $display("FAIL midrst_idle_tx: got %b want 1", tx0); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_8n1_loop();
    test_ignore_busy();
    test_back_to_back();
    test_parity_even();
    test_frame_err();
    test_break();
    test_glitch();
    test_5o2();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
